dw_prod_sum_acc_pipe: RTL and testbench

//  Pipelined, handshaked sum-of-products with group accumulation and saturation.

---
 rtl/dw_psum_pkg.sv | 25 ++
 rtl/dw_psum_sat.sv | 35 +++
 rtl/dw_prod_sum_acc_pipe.sv | 181 ++++++++++++++++++
 tb/tb_dw_prod_sum_acc_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_psum_pkg.sv
// Shared constants and width helpers for the prod-sum accumulate pipe.
// Widths are derived from operand sizes so the dot product is always exact.
package dw_psum_pkg;

  localparam bit SAT_WRAP  = 1'b0;
  localparam bit SAT_CLAMP = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int PROD_W(input int aw, input int bw);
    return aw + bw;
  endfunction

  // Sum of n products of width aw+bw never exceeds this many bits.
  function automatic int DOT_W(input int aw, input int bw, input int n);
    return aw + bw + clog2(n);
  endfunction

endpackage

// File: rtl/dw_psum_sat.sv
// Range reduction from IN_W to OUT_W bits, signed or unsigned per tc.
// Out-of-range values wrap or clamp per mode; viol flags either case.
module dw_psum_sat
  import dw_psum_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  value,
  input  logic             tc,
  input  logic             mode,
  output logic [OUT_W-1:0] result,
  output logic             viol
);

  // Wide enough to hold the input and one bit above the output sign bit.
  localparam int EW = (IN_W > OUT_W) ? IN_W : OUT_W + 1;

  logic [EW-1:0] ext;
  logic          neg;

  always_comb begin
    ext = EW'(value);
    if (tc && value[IN_W-1]) ext = ext | ~EW'({IN_W{1'b1}});
    neg = tc & ext[EW-1];
    if (tc) viol = !((ext[EW-1:OUT_W-1] == '0) || (ext[EW-1:OUT_W-1] == '1));
    else    viol = (ext[EW-1:OUT_W] != '0);
    result = ext[OUT_W-1:0];
    if (viol && (mode == SAT_CLAMP)) begin
      if (!tc) result = '1;
      else     result = {neg, {(OUT_W-1){~neg}}};
    end
  end

endmodule

// File: rtl/dw_prod_sum_acc_pipe.sv
// Handshaked sum-of-products pipe with per-group accumulation and saturation.
// The whole pipe advances as one unit whenever the output slot can take data.
module dw_prod_sum_acc_pipe
  import dw_psum_pkg::*;
#(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_STAGES = 3,
  parameter int SUM_WIDTH  = 24,
  parameter int SAT_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tc,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [A_WIDTH*NUM_INPUTS-1:0] a,
  input  logic [B_WIDTH*NUM_INPUTS-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SUM_WIDTH-1:0]          sum,
  output logic                          ovf
);

  localparam int P_W  = PROD_W(A_WIDTH, B_WIDTH);
  localparam int D_W  = DOT_W(A_WIDTH, B_WIDTH, NUM_INPUTS);
  localparam int DLY  = NUM_STAGES - 2;
  localparam bit MODE = (SAT_MODE != 0) ? SAT_CLAMP : SAT_WRAP;

  // Operands are signed or unsigned per beat, so extension is done by hand.
  function automatic logic [D_W-1:0] ext_dot(input logic [P_W-1:0] v, input logic s);
    logic [D_W-1:0] r;
    r = D_W'(v);
    if (s && v[P_W-1]) r = r | ~D_W'({P_W{1'b1}});
    return r;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---- stage 1: lane products ----
  logic [P_W-1:0] prod_c  [NUM_INPUTS];
  logic [P_W-1:0] prod_p1 [NUM_INPUTS];
  logic           vld_p1, tc_p1, first_p1, last_p1;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      prod_c[i] = {{B_WIDTH{tc & a[A_WIDTH*i + A_WIDTH-1]}}, a[A_WIDTH*i +: A_WIDTH]} *
                  {{A_WIDTH{tc & b[B_WIDTH*i + B_WIDTH-1]}}, b[B_WIDTH*i +: B_WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      tc_p1    <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else if (adv) begin
      vld_p1   <= in_valid;
      tc_p1    <= tc;
      first_p1 <= in_first;
      last_p1  <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (adv)
      for (int i = 0; i < NUM_INPUTS; i++) prod_p1[i] <= prod_c[i];
  end

  // ---- stages 2..NUM_STAGES-1: adder tree and delay ----
  logic [D_W-1:0] dot_c, dot_f;
  logic           vld_f, tc_f, first_f, last_f;

  always_comb begin
    dot_c = '0;
    for (int i = 0; i < NUM_INPUTS; i++) dot_c = dot_c + ext_dot(prod_p1[i], tc_p1);
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign dot_f   = dot_c;
      assign vld_f   = vld_p1;
      assign tc_f    = tc_p1;
      assign first_f = first_p1;
      assign last_f  = last_p1;
    end else begin : g_dly
      logic [D_W-1:0] dot_p2   [DLY];
      logic           vld_p2   [DLY];
      logic           tc_p2    [DLY];
      logic           first_p2 [DLY];
      logic           last_p2  [DLY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DLY; k++) begin
            vld_p2[k]   <= 1'b0;
            tc_p2[k]    <= 1'b0;
            first_p2[k] <= 1'b0;
            last_p2[k]  <= 1'b0;
          end
        end else if (adv) begin
          vld_p2[0]   <= vld_p1;
          tc_p2[0]    <= tc_p1;
          first_p2[0] <= first_p1;
          last_p2[0]  <= last_p1;
          for (int k = 1; k < DLY; k++) begin
            vld_p2[k]   <= vld_p2[k-1];
            tc_p2[k]    <= tc_p2[k-1];
            first_p2[k] <= first_p2[k-1];
            last_p2[k]  <= last_p2[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          dot_p2[0] <= dot_c;
          for (int k = 1; k < DLY; k++) dot_p2[k] <= dot_p2[k-1];
        end
      end

      assign dot_f   = dot_p2[DLY-1];
      assign vld_f   = vld_p2[DLY-1];
      assign tc_f    = tc_p2[DLY-1];
      assign first_f = first_p2[DLY-1];
      assign last_f  = last_p2[DLY-1];
    end
  endgenerate

  // ---- final stage: accumulate, range check, output register ----
  logic [SUM_WIDTH-1:0] dot_s, acc, nxt;
  logic [SUM_WIDTH:0]   sum_in;
  logic                 dot_viol, acc_viol, grp_ovf, grp_ovf_nxt;

  dw_psum_sat #(.IN_W(D_W), .OUT_W(SUM_WIDTH)) u_sat_dot (
    .value  (dot_f),
    .tc     (tc_f),
    .mode   (MODE),
    .result (dot_s),
    .viol   (dot_viol)
  );

  assign sum_in = first_f ? {tc_f & dot_s[SUM_WIDTH-1], dot_s}
                          : {tc_f & dot_s[SUM_WIDTH-1], dot_s} + {tc_f & acc[SUM_WIDTH-1], acc};

  dw_psum_sat #(.IN_W(SUM_WIDTH+1), .OUT_W(SUM_WIDTH)) u_sat_acc (
    .value  (sum_in),
    .tc     (tc_f),
    .mode   (MODE),
    .result (nxt),
    .viol   (acc_viol)
  );

  assign grp_ovf_nxt = (!first_f & grp_ovf) | dot_viol | acc_viol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      grp_ovf   <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (vld_f) begin
        acc     <= nxt;
        grp_ovf <= grp_ovf_nxt;
        if (last_f) begin
          sum <= nxt;
          ovf <= grp_ovf_nxt;
        end
      end
      out_valid <= vld_f & last_f;
    end
  end

endmodule

// File: tb/tb_dw_prod_sum_acc_pipe.sv
// Directed bench: a 24-bit clamping pipe alongside 16-bit clamp and wrap pipes,
// all driven from the same beat stream.
module tb_dw_prod_sum_acc_pipe;

  logic        clk = 1'b0;
  logic        rst_n, tc, in_valid, in_first, in_last, out_ready;
  logic [31:0] a, b;

  logic        rdy24, vld24, ovf24;
  logic [23:0] sum24;
  logic        rdy_c, vld_c, ovf_c;
  logic [15:0] sum_c;
  logic        rdy_w, vld_w, ovf_w;
  logic [15:0] sum_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dw_prod_sum_acc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .NUM_INPUTS(4), .NUM_STAGES(3),
                         .SUM_WIDTH(24), .SAT_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .tc(tc), .in_valid(in_valid), .in_ready(rdy24),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(vld24), .out_ready(out_ready), .sum(sum24), .ovf(ovf24));

  dw_prod_sum_acc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .NUM_INPUTS(4), .NUM_STAGES(3),
                         .SUM_WIDTH(16), .SAT_MODE(1)) dut_c16 (
    .clk(clk), .rst_n(rst_n), .tc(tc), .in_valid(in_valid), .in_ready(rdy_c),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(vld_c), .out_ready(out_ready), .sum(sum_c), .ovf(ovf_c));

  dw_prod_sum_acc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .NUM_INPUTS(4), .NUM_STAGES(3),
                         .SUM_WIDTH(16), .SAT_MODE(0)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .tc(tc), .in_valid(in_valid), .in_ready(rdy_w),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(vld_w), .out_ready(out_ready), .sum(sum_w), .ovf(ovf_w));

  function automatic logic [31:0] lanes(input int l0, input int l1, input int l2, input int l3);
    logic [31:0] r;
    r = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    return r;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Presents one beat at a falling edge and returns at the falling edge after it is taken.
  task automatic drive_beat(input logic t, input logic f, input logic l,
                            input logic [31:0] av, input logic [31:0] bv);
    int w;
    tc = t; in_first = f; in_last = l; a = av; b = bv; in_valid = 1'b1;
    w = 0;
    while (!rdy24 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!rdy24) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready got %0b want 1", rdy24);
    end
    @(negedge clk);
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (vld24) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; tc = 1'b0; a = '0; b = '0;
    idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b0 || sum24 !== 24'd0 || ovf24 !== 1'b0 || rdy24 !== 1'b1)
      $display("FAIL reset_state: got vld=%0b sum=%0d ovf=%0b rdy=%0b want 0 0 0 1",
               vld24, sum24, ovf24, rdy24);
    else n_pass++;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    drive_beat(1'b0, 1'b1, 1'b1, lanes(3, 3, 3, 3), lanes(3, 3, 3, 3));
    idle();
    @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b0) $display("FAIL latency_early: out_valid got %0b want 0", vld24);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b1 || sum24 !== 24'd36 || ovf24 !== 1'b0)
      $display("FAIL basic_dot: got vld=%0b sum=%0d ovf=%0b want 1 36 0", vld24, sum24, ovf24);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b0) $display("FAIL pop: out_valid got %0b want 0", vld24);
    else n_pass++;
  endtask

  task automatic test_signed();
    bit ok;
    drive_beat(1'b1, 1'b1, 1'b1, lanes(-128, -128, 1, 1), lanes(-128, -128, -1, 2));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok) $display("FAIL signed_timeout: out_valid got 0 want 1");
    else n_pass++;
    n_checks++;
    if (sum24 !== 24'd32769 || ovf24 !== 1'b0)
      $display("FAIL signed_sum: got %0d ovf=%0b want 32769 0", sum24, ovf24);
    else n_pass++;
    n_checks++;
    if (sum_c !== 16'h7FFF || ovf_c !== 1'b1)
      $display("FAIL signed_dot_clamp16: got %0d ovf=%0b want 32767 1", sum_c, ovf_c);
    else n_pass++;
    n_checks++;
    if (sum_w !== 16'h8001 || ovf_w !== 1'b1)
      $display("FAIL signed_dot_wrap16: got %0d ovf=%0b want 32769 1", sum_w, ovf_w);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_group_backpressure();
    bit ok;
    out_ready = 1'b0;
    drive_beat(1'b0, 1'b1, 1'b0, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    drive_beat(1'b0, 1'b0, 1'b0, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    drive_beat(1'b0, 1'b0, 1'b1, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok) $display("FAIL group_timeout: out_valid got 0 want 1");
    else n_pass++;
    n_checks++;
    if (sum24 !== 24'd300 || ovf24 !== 1'b0)
      $display("FAIL group_sum: got %0d ovf=%0b want 300 0", sum24, ovf24);
    else n_pass++;
    tc = 1'b0; in_first = 1'b1; in_last = 1'b1;
    a = lanes(3, 3, 3, 3); b = lanes(3, 3, 3, 3); in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (vld24 !== 1'b1 || sum24 !== 24'd300 || rdy24 !== 1'b0)
        $display("FAIL stall_hold: got vld=%0b sum=%0d rdy=%0b want 1 300 0", vld24, sum24, rdy24);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    n_checks++;
    if (vld24 !== 1'b0) $display("FAIL stall_pop: out_valid got %0b want 0", vld24);
    else n_pass++;
    wait_out(ok);
    n_checks++;
    if (!ok || sum24 !== 24'd36)
      $display("FAIL stalled_beat: got vld=%0b sum=%0d want 1 36", vld24, sum24);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    bit ok;
    drive_beat(1'b0, 1'b1, 1'b0, lanes(200, 200, 200, 200), lanes(75, 75, 75, 75));
    drive_beat(1'b0, 1'b0, 1'b1, lanes(200, 200, 200, 200), lanes(75, 75, 75, 75));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok) $display("FAIL sat_timeout: out_valid got 0 want 1");
    else n_pass++;
    n_checks++;
    if (sum_c !== 16'd65535 || ovf_c !== 1'b1)
      $display("FAIL sat_clamp16: got %0d ovf=%0b want 65535 1", sum_c, ovf_c);
    else n_pass++;
    n_checks++;
    if (sum_w !== 16'd54464 || ovf_w !== 1'b1)
      $display("FAIL sat_wrap16: got %0d ovf=%0b want 54464 1", sum_w, ovf_w);
    else n_pass++;
    n_checks++;
    if (sum24 !== 24'd120000 || ovf24 !== 1'b0)
      $display("FAIL sat_wide24: got %0d ovf=%0b want 120000 0", sum24, ovf24);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_signed_clamp();
    bit ok;
    drive_beat(1'b1, 1'b1, 1'b0, lanes(-100, -100, -100, -100), lanes(50, 50, 50, 50));
    drive_beat(1'b1, 1'b0, 1'b1, lanes(-100, -100, -100, -100), lanes(50, 50, 50, 50));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok) $display("FAIL sclamp_timeout: out_valid got 0 want 1");
    else n_pass++;
    n_checks++;
    if (sum_c !== 16'h8000 || ovf_c !== 1'b1)
      $display("FAIL sclamp16: got %0d ovf=%0b want 32768 1", sum_c, ovf_c);
    else n_pass++;
    n_checks++;
    if (sum_w !== 16'd25536 || ovf_w !== 1'b1)
      $display("FAIL swrap16: got %0d ovf=%0b want 25536 1", sum_w, ovf_w);
    else n_pass++;
    n_checks++;
    if (sum24 !== 24'hFF63C0 || ovf24 !== 1'b0)
      $display("FAIL swide24: got %0d ovf=%0b want 16737216 0", sum24, ovf24);
    else n_pass++;
    @(negedge clk);
    drive_beat(1'b1, 1'b1, 1'b1, lanes(1, 1, 1, 2), lanes(1, 1, 1, 1));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok || sum_c !== 16'd5 || ovf_c !== 1'b0)
      $display("FAIL ovf_clear: got vld=%0b sum=%0d ovf=%0b want 1 5 0", vld24, sum_c, ovf_c);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_beat(1'b0, 1'b1, 1'b1, lanes(3, 3, 3, 3), lanes(3, 3, 3, 3));
    drive_beat(1'b1, 1'b1, 1'b1, lanes(-128, -128, 1, 1), lanes(-128, -128, -1, 2));
    drive_beat(1'b0, 1'b1, 1'b1, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    idle();
    n_checks++;
    if (vld24 !== 1'b1 || sum24 !== 24'd36)
      $display("FAIL b2b_first: got vld=%0b sum=%0d want 1 36", vld24, sum24);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b1 || sum24 !== 24'd32769)
      $display("FAIL b2b_second: got vld=%0b sum=%0d want 1 32769", vld24, sum24);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vld24 !== 1'b1 || sum24 !== 24'd100)
      $display("FAIL b2b_third: got vld=%0b sum=%0d want 1 100", vld24, sum24);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_group();
    bit ok;
    bit seen;
    drive_beat(1'b0, 1'b1, 1'b0, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    drive_beat(1'b0, 1'b0, 1'b0, lanes(5, 5, 0, 0), lanes(10, 10, 0, 0));
    idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vld24 !== 1'b0 || sum24 !== 24'd0 || ovf24 !== 1'b0)
      $display("FAIL async_reset: got vld=%0b sum=%0d ovf=%0b want 0 0 0", vld24, sum24, ovf24);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vld24) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL partial_emitted: out_valid seen got 1 want 0");
    else n_pass++;
    drive_beat(1'b0, 1'b1, 1'b1, lanes(7, 0, 0, 0), lanes(1, 0, 0, 0));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok || sum24 !== 24'd7 || ovf24 !== 1'b0)
      $display("FAIL after_reset: got vld=%0b sum=%0d ovf=%0b want 1 7 0", vld24, sum24, ovf24);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_continue();
    bit ok;
    drive_beat(1'b0, 1'b0, 1'b1, lanes(1, 1, 1, 2), lanes(1, 1, 1, 1));
    idle();
    wait_out(ok);
    n_checks++;
    if (!ok || sum24 !== 24'd12 || ovf24 !== 1'b0)
      $display("FAIL continue_acc: got vld=%0b sum=%0d ovf=%0b want 1 12 0", vld24, sum24, ovf24);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed();
    test_group_backpressure();
    test_saturation();
    test_signed_clamp();
    test_back_to_back();
    test_reset_mid_group();
    test_continue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
